// File: rtl/alu_seq_pkg.sv
// Shared types for alu_seq: operation encodings, flag bundle and FSM states.
// The BUSY state exists only when ALU_SEQ_MUL_EN is defined.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpOr  = 3'b010,
    OpAnd = 3'b011,
    OpXor = 3'b100,
    OpSll = 3'b101,
    OpSrl = 3'b110,
    OpMul = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } alu_state_e;
`else
  typedef enum logic {
    StIdle = 1'b0
  } alu_state_e;
`endif

  function automatic alu_flags_t mk_flags(input logic zero, input logic neg, input logic carry,
                                          input logic ovf);
    alu_flags_t f;
    f.z = zero;
    f.n = neg;
    f.c = carry;
    f.v = ovf;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// Built only when ALU_SEQ_MUL_EN is defined. i_start latches the operands;
// WIDTH iterations follow, and o_done/o_prod present the final accumulator
// value combinationally during the last iteration so the caller can load it
// on the same edge the multiplier goes idle.
`ifdef ALU_SEQ_MUL_EN
module alu_seq_mul
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_prod
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic               r_busy;
  logic [CntW-1:0]    r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] w_acc_next;

  // Accumulate the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  end

  assign o_done = r_busy && (r_cnt == CntW'(WIDTH - 1));
  assign o_prod = w_acc_next;

  // Operand latch on start, then one shift-add step per cycle while busy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      r_cnt    <= r_cnt + CntW'(1);
      if (o_done) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end
    end
  end

endmodule
`endif

// File: rtl/alu_seq.sv
// Handshaked ALU: valid/ready in, registered result + {Z,N,C,V} flags out.
// Define ALU_SEQ_MUL_EN to build the multi-cycle shift-add multiplier;
// without it MUL completes in one cycle with a zero result.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_res,
  output logic [3:0]       o_flags
);

  localparam int unsigned ShiftW = $clog2(WIDTH);

  alu_state_e       r_state;
  alu_state_e       w_state_next;
  logic             r_valid;
  logic [WIDTH-1:0] r_res;
  alu_flags_t       r_flags;

  alu_op_e          w_op;
  logic             w_accept;
  logic             w_drain;
  logic             w_load;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c;
  logic             w_alu_v;
  logic [WIDTH-1:0] w_ld_res;
  logic             w_ld_c;
  logic             w_ld_v;

  assign w_op     = alu_op_e'(i_op);
  assign w_accept = i_valid && o_ready;
  assign w_drain  = r_valid && i_ready;

`ifdef ALU_SEQ_MUL_EN
  logic               w_mul_start;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;

  assign w_mul_start = w_accept && (w_op == OpMul);
  // The output register is always empty while BUSY, so the final iteration loads directly.
  assign w_load      = w_mul_done || (w_accept && (w_op != OpMul));

  alu_seq_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_start(w_mul_start),
    .i_a    (i_a),
    .i_b    (i_b),
    .o_done (w_mul_done),
    .o_prod (w_prod)
  );
`else
  assign w_load = w_accept;
`endif

  // Single-cycle datapath; MUL yields zero here (the multiplier path overrides it when built).
  always_comb begin
    w_add     = {1'b0, i_a} + {1'b0, i_b};
    w_sub     = {1'b0, i_a} - {1'b0, i_b};
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (w_op)
      OpAdd: begin
        w_alu_res = w_add[WIDTH-1:0];
        w_alu_c   = w_add[WIDTH];
        w_alu_v   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_add[WIDTH-1] != i_a[WIDTH-1]);
      end
      OpSub: begin
        w_alu_res = w_sub[WIDTH-1:0];
        // Top bit of the zero-extended difference is the borrow, i.e. a < b.
        w_alu_c   = w_sub[WIDTH];
        w_alu_v   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_sub[WIDTH-1] != i_a[WIDTH-1]);
      end
      OpOr:    w_alu_res = i_a | i_b;
      OpAnd:   w_alu_res = i_a & i_b;
      OpXor:   w_alu_res = i_a ^ i_b;
      OpSll:   w_alu_res = i_a << i_b[ShiftW-1:0];
      OpSrl:   w_alu_res = i_a >> i_b[ShiftW-1:0];
      default: w_alu_res = '0;
    endcase
  end

  // Select what gets written into the output register.
  always_comb begin
    w_ld_res = w_alu_res;
    w_ld_c   = w_alu_c;
    w_ld_v   = w_alu_v;
`ifdef ALU_SEQ_MUL_EN
    if (w_mul_done) begin
      w_ld_res = w_prod[WIDTH-1:0];
      w_ld_c   = |w_prod[2*WIDTH-1:WIDTH];
      w_ld_v   = 1'b0;
    end
`endif
  end

  // Output register: load has priority over drain so accept+drain keeps o_valid high.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_res   <= '0;
      r_flags <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_res   <= w_ld_res;
      r_flags <= mk_flags((w_ld_res == '0), w_ld_res[WIDTH-1], w_ld_c, w_ld_v);
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
`ifdef ALU_SEQ_MUL_EN
    case (r_state)
      StIdle:  if (w_mul_start) w_state_next = StBusy;
      StBusy:  if (w_mul_done) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
`else
    w_state_next = StIdle;
`endif
  end

  // FSM outputs: ready only when idle and the output slot is free or draining.
  always_comb begin
    o_ready = (r_state == StIdle) && (!r_valid || i_ready);
  end

  assign o_valid = r_valid;
  assign o_res   = r_res;
  assign o_flags = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8). Multiplier scenarios are built
// when ALU_SEQ_MUL_EN is defined, the single-cycle MUL scenario otherwise.
module tb_alu_seq;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             valid_out;
  logic             ready_in;
  logic [WIDTH-1:0] res;
  logic [3:0]       flags;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_seq #(
    .WIDTH(WIDTH)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_valid(valid_in),
    .o_ready(ready_out),
    .i_a    (a),
    .i_b    (b),
    .i_op   (op),
    .o_valid(valid_out),
    .i_ready(ready_in),
    .o_res  (res),
    .o_flags(flags)
  );

  // Reference model: returns {result[7:0], Z, N, C, V} from plain integer arithmetic.
  function automatic logic [11:0] model(input int unsigned mop, input int unsigned ma,
                                        input int unsigned mb);
    int r, sa, sb, s;
    logic c, v;
    logic [7:0] r8;
    c  = 1'b0;
    v  = 1'b0;
    sa = (ma >= 128) ? int'(ma) - 256 : int'(ma);
    sb = (mb >= 128) ? int'(mb) - 256 : int'(mb);
    case (mop)
      0: begin r = int'(ma + mb); c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
      1: begin r = int'(ma) - int'(mb); c = (ma < mb); s = sa - sb; v = (s > 127) || (s < -128); end
      2: r = int'(ma | mb);
      3: r = int'(ma & mb);
      4: r = int'(ma ^ mb);
      5: r = int'(ma << (mb % 8));
      6: r = int'(ma >> (mb % 8));
      default: begin
`ifdef ALU_SEQ_MUL_EN
        r = int'(ma * mb);
        c = (r > 255);
`else
        r = 0;
`endif
      end
    endcase
    r8 = 8'(r & 255);
    return {r8, (r8 == 8'd0), r8[7], c, v};
  endfunction

  // One single-cycle op with i_ready=1: checks acceptance and 1-cycle latency.
  task automatic do_op(input string name, input logic [2:0] top, input logic [7:0] ta,
                       input logic [7:0] tb, input logic [7:0] e_res, input logic [3:0] e_flg);
    @(negedge clk);
    valid_in = 1'b1;
    op       = top;
    a        = ta;
    b        = tb;
    ready_in = 1'b1;
    #1;
    n_tests++;
    if (ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready: got o_ready=%b expected 1", name, ready_out);
    end
    @(negedge clk);
    valid_in = 1'b0;
    n_tests++;
    if (valid_out !== 1'b1 || res !== e_res || flags !== e_flg) begin
      n_fail++;
      $display("FAIL %s: got valid=%b res=%h flags=%b expected valid=1 res=%h flags=%b",
               name, valid_out, res, flags, e_res, e_flg);
    end
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    op       = 3'd0;
    a        = '0;
    b        = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (valid_out !== 1'b0 || res !== 8'h00 || flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b res=%h flags=%b expected 0/00/0000",
               valid_out, res, flags);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got o_ready=%b expected 1", ready_out);
    end
  endtask

  task automatic test_directed;
    do_op("add_ff_01", 3'd0, 8'hFF, 8'h01, 8'h00, 4'b1010);
    do_op("sub_80_01", 3'd1, 8'h80, 8'h01, 8'h7F, 4'b0001);
    do_op("sub_01_02", 3'd1, 8'h01, 8'h02, 8'hFF, 4'b0110);
    do_op("sll_01_0b", 3'd5, 8'h01, 8'h0B, 8'h08, 4'b0000);
    do_op("srl_80_07", 3'd6, 8'h80, 8'h07, 8'h01, 4'b0000);
    do_op("and_f0_0f", 3'd3, 8'hF0, 8'h0F, 8'h00, 4'b1000);
  endtask

  // Random single-cycle ops issued every cycle with i_ready=1 (full throughput).
  task automatic test_stream;
    logic [11:0] exp_prev;
    bit          have;
    int unsigned rop, ra, rb;
    have = 1'b0;
    exp_prev = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (have) begin
        n_tests++;
        if (valid_out !== 1'b1 || {res, flags} !== exp_prev) begin
          n_fail++;
          $display("FAIL stream_%0d: got valid=%b res=%h flags=%b expected res=%h flags=%b",
                   i, valid_out, res, flags, exp_prev[11:4], exp_prev[3:0]);
        end
      end
      rop = $urandom_range(0, 6);
      ra  = $urandom_range(0, 255);
      rb  = $urandom_range(0, 255);
      valid_in = 1'b1;
      ready_in = 1'b1;
      op = 3'(rop);
      a  = 8'(ra);
      b  = 8'(rb);
      #1;
      n_tests++;
      if (ready_out !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_ready_%0d: got o_ready=%b expected 1", i, ready_out);
      end
      exp_prev = model(rop, ra, rb);
      have = 1'b1;
    end
    @(negedge clk);
    valid_in = 1'b0;
    n_tests++;
    if (valid_out !== 1'b1 || {res, flags} !== exp_prev) begin
      n_fail++;
      $display("FAIL stream_last: got res=%h flags=%b expected res=%h flags=%b",
               res, flags, exp_prev[11:4], exp_prev[3:0]);
    end
  endtask

  // Result held for 3 cycles of backpressure; second op waits for i_ready to rise.
  task automatic test_back_to_back;
    @(negedge clk);
    ready_in = 1'b0;
    valid_in = 1'b1;
    op = 3'd0; a = 8'h12; b = 8'h34;
    #1;
    n_tests++;
    if (ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first_ready: got o_ready=%b expected 1", ready_out);
    end
    @(negedge clk);
    op = 3'd4; a = 8'hF0; b = 8'h0F;
    for (int j = 0; j < 3; j++) begin
      #1;
      n_tests++;
      if (valid_out !== 1'b1 || res !== 8'h46 || flags !== 4'b0000 || ready_out !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_hold_%0d: got valid=%b res=%h flags=%b ready=%b expected 1/46/0000/0",
                 j, valid_out, res, flags, ready_out);
      end
      @(negedge clk);
    end
    ready_in = 1'b1;
    #1;
    n_tests++;
    if (ready_out !== 1'b1 || res !== 8'h46) begin
      n_fail++;
      $display("FAIL b2b_release: got ready=%b res=%h expected 1/46", ready_out, res);
    end
    @(negedge clk);
    valid_in = 1'b0;
    n_tests++;
    if (valid_out !== 1'b1 || res !== 8'hFF || flags !== 4'b0100) begin
      n_fail++;
      $display("FAIL b2b_second: got valid=%b res=%h flags=%b expected 1/ff/0100",
               valid_out, res, flags);
    end
    @(negedge clk);
    n_tests++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_dup: got valid=%b expected 0", valid_out);
    end
  endtask

  // Random valid/ready on both sides, in-order scoreboard, all ops.
  task automatic test_random_bp;
    logic [11:0] q[$];
    logic [11:0] e;
    int unsigned rop, ra, rb;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rop = $urandom_range(0, 7);
      ra  = $urandom_range(0, 255);
      rb  = $urandom_range(0, 255);
      valid_in = ($urandom_range(0, 2) != 0);
      ready_in = ($urandom_range(0, 3) != 0);
      op = 3'(rop);
      a  = 8'(ra);
      b  = 8'(rb);
      #1;
      if (valid_out === 1'b1 && ready_in) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra_%0d: got res=%h with no outstanding op", i, res);
        end else begin
          e = q.pop_front();
          if ({res, flags} !== e) begin
            n_fail++;
            $display("FAIL bp_%0d: got res=%h flags=%b expected res=%h flags=%b",
                     i, res, flags, e[11:4], e[3:0]);
          end
        end
      end
      if (valid_in && ready_out === 1'b1) q.push_back(model(rop, ra, rb));
    end
    @(negedge clk);
    valid_in = 1'b0;
    ready_in = 1'b1;
    for (int k = 0; k < 40 && (q.size() != 0 || valid_out === 1'b1); k++) begin
      #1;
      if (valid_out === 1'b1) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_drain_extra: got res=%h with no outstanding op", res);
        end else begin
          e = q.pop_front();
          if ({res, flags} !== e) begin
            n_fail++;
            $display("FAIL bp_drain: got res=%h flags=%b expected res=%h flags=%b",
                     res, flags, e[11:4], e[3:0]);
          end
        end
      end
      @(negedge clk);
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_lost: got %0d results missing expected 0", q.size());
    end
  endtask

`ifdef ALU_SEQ_MUL_EN
  task automatic test_mul;
    @(negedge clk);
    valid_in = 1'b1; ready_in = 1'b1;
    op = 3'd7; a = 8'd13; b = 8'd11;
    #1;
    n_tests++;
    if (ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_ready: got o_ready=%b expected 1", ready_out);
    end
    @(negedge clk);
    // Garbage while BUSY must be ignored, and changed operands must not matter.
    op = 3'd0;
    for (int j = 0; j < 8; j++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      #1;
      n_tests++;
      if (valid_out !== 1'b0 || ready_out !== 1'b0) begin
        n_fail++;
        $display("FAIL mul_busy_%0d: got valid=%b ready=%b expected 0/0", j, valid_out, ready_out);
      end
      @(negedge clk);
    end
    valid_in = 1'b0;
    n_tests++;
    if (valid_out !== 1'b1 || res !== 8'h8F || flags !== 4'b0100) begin
      n_fail++;
      $display("FAIL mul_13x11: got valid=%b res=%h flags=%b expected 1/8f/0100",
               valid_out, res, flags);
    end
    @(negedge clk);
    n_tests++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_no_extra: got valid=%b expected 0", valid_out);
    end
    valid_in = 1'b1;
    op = 3'd7; a = 8'h10; b = 8'h10;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (8) @(negedge clk);
    n_tests++;
    if (valid_out !== 1'b1 || res !== 8'h00 || flags !== 4'b1010) begin
      n_fail++;
      $display("FAIL mul_10x10: got valid=%b res=%h flags=%b expected 1/00/1010",
               valid_out, res, flags);
    end
  endtask

  task automatic test_mul_abort;
    bit stale;
    @(negedge clk);
    valid_in = 1'b1; ready_in = 1'b1;
    op = 3'd7; a = 8'h37; b = 8'h59;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_state: got valid=%b ready=%b expected 0/1", valid_out, ready_out);
    end
    stale = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (valid_out !== 1'b0) stale = 1'b1;
    end
    n_tests++;
    if (stale) begin
      n_fail++;
      $display("FAIL abort_stale: got o_valid=1 after abort expected 0");
    end
    do_op("abort_add_2_3", 3'd0, 8'd2, 8'd3, 8'h05, 4'b0000);
  endtask
`else
  task automatic test_mul_stub;
    do_op("mul_5x5_stub", 3'd7, 8'd5, 8'd5, 8'h00, 4'b1000);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_stream();
    test_back_to_back();
`ifdef ALU_SEQ_MUL_EN
    test_mul();
    test_mul_abort();
`else
    test_mul_stub();
`endif
    test_random_bp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
